gp_regfile_wb: RTL and testbench

GP_REGFILE_WB -- requirements
Module: gp_regfile_wb

---
 rtl/gp_regfile_wb_pkg.sv | 14 +
 rtl/gp_regfile_core.sv | 61 ++++++
 rtl/gp_regfile_wb.sv | 104 ++++++++++
 tb/tb_gp_regfile_wb.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/gp_regfile_wb_pkg.sv
// Shared CPU definitions for the write-back register file slice:
// datapath/address widths, register count and hazard FSM state encoding.
package gp_regfile_wb_pkg;

  localparam int GP_DATA_W   = 10;
  localparam int GP_ADDR_W   = 3;
  localparam int GP_NUM_REGS = 1 << GP_ADDR_W;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } hz_state_e;

endpackage

// File: rtl/gp_regfile_core.sv
// General-purpose register array with write-back bypass onto both read ports.
// Register 0 is never written, so it always reads as zero.
module gp_regfile_core
  import gp_regfile_wb_pkg::*;
#(
  parameter int DATA_W = GP_DATA_W,
  parameter int ADDR_W = GP_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2
);

  localparam int NUM_REGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_r [NUM_REGS];
  logic              wr_hit_s;

  // Gated by reset so the bypass cannot leak write data while in reset.
  assign wr_hit_s = reset && wr_en && (wb_addr != {ADDR_W{1'b0}});

  // Register array update with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_hit_s) begin
      regs_r[wb_addr] <= wb_data;
    end else begin
      regs_r[wb_addr] <= regs_r[wb_addr];
    end
  end

  // Read port 1 with same-cycle write-back bypass.
  always_comb begin
    rd_data1 = regs_r[rd_addr1];
    if (wr_hit_s && (rd_addr1 == wb_addr)) begin
      rd_data1 = wb_data;
    end else begin
      rd_data1 = regs_r[rd_addr1];
    end
  end

  // Read port 2 with same-cycle write-back bypass.
  always_comb begin
    rd_data2 = regs_r[rd_addr2];
    if (wr_hit_s && (rd_addr2 == wb_addr)) begin
      rd_data2 = wb_data;
    end else begin
      rd_data2 = regs_r[rd_addr2];
    end
  end

endmodule

// File: rtl/gp_regfile_wb.sv
// Write-back stage register file plus load-use hazard detection: a one-cycle
// stall FSM that freezes fetch/decode and injects a bubble, and a saturating stall counter.
module gp_regfile_wb
  import gp_regfile_wb_pkg::*;
#(
  parameter int DATA_W = GP_DATA_W,
  parameter int ADDR_W = GP_ADDR_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              mem_re,
  input  logic              gp_reg_wb,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              ex_mem_re,
  input  logic [ADDR_W-1:0] ex_dest_addr,
  output logic              pipe_en,
  output logic              bubble,
  output logic [CNT_W-1:0]  stall_cnt
);

  hz_state_e         state_r;
  hz_state_e         next_state_s;
  logic [DATA_W-1:0] wb_data_s;
  logic              hazard_s;
  logic              stall_enter_s;
  logic [CNT_W-1:0]  stall_cnt_r;

  assign wb_data_s = mem_re ? ram_rdata : alu_result;

  gp_regfile_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (gp_reg_wb),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data_s),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2)
  );

  // Reset gating keeps pipe_en/bubble at their idle values while reset is low.
  assign hazard_s = reset && ex_mem_re && (ex_dest_addr != {ADDR_W{1'b0}}) &&
                    ((ex_dest_addr == rd_addr1) || (ex_dest_addr == rd_addr2));

  // Hazard FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Hazard FSM next-state and pipeline control.
  always_comb begin
    next_state_s  = state_r;
    pipe_en       = 1'b1;
    bubble        = 1'b0;
    stall_enter_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (hazard_s) begin
          next_state_s  = ST_STALL;
          pipe_en       = 1'b0;
          bubble        = 1'b1;
          stall_enter_s = 1'b1;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_STALL: begin
        next_state_s = ST_RUN;
      end
      default: begin
        next_state_s = ST_RUN;
      end
    endcase
  end

  // Saturating count of RUN->STALL transitions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_enter_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_gp_regfile_wb.sv
// Directed table-driven bench for gp_regfile_wb: per-cycle vectors with
// hand-computed expectations, plus saturation and reset-during-stall sequences.
module tb_gp_regfile_wb;

  logic       clk;
  logic       reset;
  logic [9:0] alu_result;
  logic [9:0] ram_rdata;
  logic       mem_re;
  logic       gp_reg_wb;
  logic [2:0] wb_addr;
  logic [2:0] rd_addr1;
  logic [2:0] rd_addr2;
  logic [9:0] rd_data1;
  logic [9:0] rd_data2;
  logic       ex_mem_re;
  logic [2:0] ex_dest_addr;
  logic       pipe_en;
  logic       bubble;
  logic [7:0] stall_cnt;

  int n_tests;
  int n_fail;

  gp_regfile_wb dut (
    .clk          (clk),
    .reset        (reset),
    .alu_result   (alu_result),
    .ram_rdata    (ram_rdata),
    .mem_re       (mem_re),
    .gp_reg_wb    (gp_reg_wb),
    .wb_addr      (wb_addr),
    .rd_addr1     (rd_addr1),
    .rd_addr2     (rd_addr2),
    .rd_data1     (rd_data1),
    .rd_data2     (rd_data2),
    .ex_mem_re    (ex_mem_re),
    .ex_dest_addr (ex_dest_addr),
    .pipe_en      (pipe_en),
    .bubble       (bubble),
    .stall_cnt    (stall_cnt)
  );

  // Rising edges at 5, 15, 25 ...; inputs change on falling edges.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic       mre;
    logic [2:0] wa;
    logic [9:0] alu;
    logic [9:0] ram;
    logic [2:0] ra1;
    logic [2:0] ra2;
    logic       exre;
    logic [2:0] exd;
    logic [9:0] e_rd1;
    logic [9:0] e_rd2;
    logic       e_pe;
    logic       e_bub;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic mre, input logic [2:0] wa,
                       input logic [9:0] alu, input logic [9:0] ram,
                       input logic [2:0] ra1, input logic [2:0] ra2,
                       input logic exre, input logic [2:0] exd);
    gp_reg_wb    = we;
    mem_re       = mre;
    wb_addr      = wa;
    alu_result   = alu;
    ram_rdata    = ram;
    rd_addr1     = ra1;
    rd_addr2     = ra2;
    ex_mem_re    = exre;
    ex_dest_addr = exd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'd0, 10'h000, 10'h000, 3'd0, 3'd0, 1'b0, 3'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    //            we    mre   wa    alu      ram      ra1   ra2   exre  exd   rd1      rd2      pe    bub   cnt
    vecs[0]  = '{1'b0, 1'b0, 3'd0, 10'h000, 10'h000, 3'd0, 3'd3, 1'b0, 3'd0, 10'h000, 10'h000, 1'b1, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 1'b0, 3'd3, 10'h2A5, 10'h111, 3'd3, 3'd0, 1'b0, 3'd0, 10'h2A5, 10'h000, 1'b1, 1'b0, 8'd0};
    vecs[2]  = '{1'b0, 1'b0, 3'd0, 10'h000, 10'h000, 3'd3, 3'd1, 1'b0, 3'd0, 10'h2A5, 10'h000, 1'b1, 1'b0, 8'd0};
    vecs[3]  = '{1'b1, 1'b1, 3'd5, 10'h0AA, 10'h13C, 3'd3, 3'd5, 1'b0, 3'd0, 10'h2A5, 10'h13C, 1'b1, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 1'b0, 3'd0, 10'h000, 10'h000, 3'd5, 3'd3, 1'b0, 3'd0, 10'h13C, 10'h2A5, 1'b1, 1'b0, 8'd0};
    vecs[5]  = '{1'b1, 1'b0, 3'd0, 10'h3FF, 10'h000, 3'd0, 3'd0, 1'b0, 3'd0, 10'h000, 10'h000, 1'b1, 1'b0, 8'd0};
    vecs[6]  = '{1'b0, 1'b0, 3'd0, 10'h000, 10'h000, 3'd0, 3'd5, 1'b0, 3'd0, 10'h000, 10'h13C, 1'b1, 1'b0, 8'd0};
    vecs[7]  = '{1'b0, 1'b0, 3'd0, 10'h000, 10'h000, 3'd0, 3'd0, 1'b1, 3'd0, 10'h000, 10'h000, 1'b1, 1'b0, 8'd0};
    vecs[8]  = '{1'b0, 1'b0, 3'd0, 10'h000, 10'h000, 3'd4, 3'd0, 1'b0, 3'd4, 10'h000, 10'h000, 1'b1, 1'b0, 8'd0};
    vecs[9]  = '{1'b1, 1'b0, 3'd4, 10'h055, 10'h000, 3'd4, 3'd5, 1'b1, 3'd4, 10'h055, 10'h13C, 1'b0, 1'b1, 8'd0};
    vecs[10] = '{1'b0, 1'b0, 3'd0, 10'h000, 10'h000, 3'd4, 3'd5, 1'b1, 3'd4, 10'h055, 10'h13C, 1'b1, 1'b0, 8'd1};
    vecs[11] = '{1'b0, 1'b0, 3'd0, 10'h000, 10'h000, 3'd0, 3'd5, 1'b1, 3'd5, 10'h000, 10'h13C, 1'b0, 1'b1, 8'd1};
    vecs[12] = '{1'b0, 1'b0, 3'd0, 10'h000, 10'h000, 3'd0, 3'd0, 1'b0, 3'd0, 10'h000, 10'h000, 1'b1, 1'b0, 8'd2};
    vecs[13] = '{1'b0, 1'b0, 3'd0, 10'h000, 10'h000, 3'd4, 3'd3, 1'b0, 3'd0, 10'h055, 10'h2A5, 1'b1, 1'b0, 8'd2};

    // Reset with a live write and hazard on the inputs: outputs must stay idle.
    reset = 1'b0;
    drive(1'b1, 1'b0, 3'd3, 10'h1FF, 10'h000, 3'd3, 3'd3, 1'b1, 3'd3);
    #1;
    chk("rst_rd1", 32'(rd_data1), 32'h0);
    chk("rst_rd2", 32'(rd_data2), 32'h0);
    chk("rst_pe",  32'(pipe_en), 32'h1);
    chk("rst_bub", 32'(bubble), 32'h0);
    chk("rst_cnt", 32'(stall_cnt), 32'h0);
    @(negedge clk);
    @(negedge clk);
    idle();
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].we, vecs[i].mre, vecs[i].wa, vecs[i].alu, vecs[i].ram,
            vecs[i].ra1, vecs[i].ra2, vecs[i].exre, vecs[i].exd);
      #1;
      chk($sformatf("v%0d_rd1", i), 32'(rd_data1), 32'(vecs[i].e_rd1));
      chk($sformatf("v%0d_rd2", i), 32'(rd_data2), 32'(vecs[i].e_rd2));
      chk($sformatf("v%0d_pe", i),  32'(pipe_en), 32'(vecs[i].e_pe));
      chk($sformatf("v%0d_bub", i), 32'(bubble), 32'(vecs[i].e_bub));
      chk($sformatf("v%0d_cnt", i), 32'(stall_cnt), 32'(vecs[i].e_cnt));
      @(negedge clk);
    end

    // Persistent hazard: every RUN cycle stalls, so 600 cycles = 300 more stalls.
    drive(1'b0, 1'b0, 3'd0, 10'h000, 10'h000, 3'd6, 3'd0, 1'b1, 3'd6);
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
    end
    idle();
    #1;
    chk("sat_cnt", 32'(stall_cnt), 32'd255);
    @(negedge clk);
    chk("sat_hold", 32'(stall_cnt), 32'd255);

    // Enter STALL with r3/r4/r5 loaded, then pulse reset mid-stall.
    drive(1'b0, 1'b0, 3'd0, 10'h000, 10'h000, 3'd4, 3'd0, 1'b1, 3'd4);
    #1;
    chk("pre_bub", 32'(bubble), 32'h1);
    @(negedge clk);
    drive(1'b1, 1'b0, 3'd3, 10'h2CC, 10'h000, 3'd3, 3'd5, 1'b1, 3'd3);
    reset = 1'b0;
    #1;
    chk("mid_rd1", 32'(rd_data1), 32'h0);
    chk("mid_rd2", 32'(rd_data2), 32'h0);
    chk("mid_pe",  32'(pipe_en), 32'h1);
    chk("mid_bub", 32'(bubble), 32'h0);
    chk("mid_cnt", 32'(stall_cnt), 32'h0);
    @(negedge clk);
    idle();
    reset = 1'b1;
    for (int r = 1; r < 8; r++) begin
      rd_addr1 = 3'(r);
      rd_addr2 = 3'(8 - r);
      #1;
      chk($sformatf("clr_r%0d", r), 32'(rd_data1), 32'h0);
      chk($sformatf("clr2_r%0d", 8 - r), 32'(rd_data2), 32'h0);
    end
    chk("post_pe",  32'(pipe_en), 32'h1);
    chk("post_bub", 32'(bubble), 32'h0);
    @(negedge clk);
    // RUN (not STALL) after release: a fresh hazard must stall immediately.
    drive(1'b0, 1'b0, 3'd0, 10'h000, 10'h000, 3'd0, 3'd2, 1'b1, 3'd2);
    #1;
    chk("post_haz_pe",  32'(pipe_en), 32'h0);
    chk("post_haz_bub", 32'(bubble), 32'h1);
    @(negedge clk);
    idle();
    #1;
    chk("post_haz_cnt", 32'(stall_cnt), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
